// File: rtl/spy_arb_pkg.sv
// Shared types and widths for the spy bus arbiter: transaction FSM states,
// spy bus address/data widths and requester count.
package spy_arb_pkg;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned NUM_REQ = 2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WS,
      WT,
      WH,
      DONE
   } state_t;

   typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage : spy_arb_pkg

// File: rtl/spy_arb_pick.sv
// Grant selection for the two spy bus requesters: a lone requester always wins,
// a tie goes to the requester that was not granted last (ptr_i).
module spy_arb_pick
   import spy_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] m_valid_i,
   input  logic               ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   always_comb begin
      grant_o = '0;
      case (m_valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = ptr_i ? 2'b01 : 2'b10;
         default: grant_o = '0;
      endcase
   end

endmodule : spy_arb_pick

// File: rtl/spy_bus_arbiter.sv
// Two-master arbiter onto the spy register bus (read strobe held READ_WAIT cycles,
// write as setup/strobe/hold). Define SPY_ARB_RR_EN for round-robin ties, else requester 0 wins.
module spy_bus_arbiter
   import spy_arb_pkg::*;
#(
   parameter int unsigned READ_WAIT = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        m_valid,
   input  logic [NUM_REQ-1:0]        m_write,
   input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
   input  logic [NUM_REQ*DATA_W-1:0] m_wdata,
   output logic [NUM_REQ-1:0]        m_ack,
   output logic [DATA_W-1:0]         m_rdata,
   output logic [ADDR_W-1:0]         eadr,
   output logic                      dbread,
   output logic                      dbwrite,
   output logic [DATA_W-1:0]         spy_out,
   input  logic [DATA_W-1:0]         spy_in
);

   localparam logic [2:0] LAST_WAIT = 3'(READ_WAIT - 1);

   state_t              state_q, state_d;
   logic [2:0]          wait_q, wait_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [ADDR_W-1:0]   eadr_q, eadr_d;
   logic [DATA_W-1:0]   spy_out_q, spy_out_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                dbread_q, dbread_d;
   logic                dbwrite_q, dbwrite_d;

   logic [NUM_REQ-1:0]  pick_grant;
   logic                pick_ptr;
   logic                pick_idx;
   logic                take;

   assign take     = (state_q == IDLE) && (|m_valid);
   assign pick_idx = pick_grant[1];

   spy_arb_pick u_pick (
      .m_valid_i (m_valid),
      .ptr_i     (pick_ptr),
      .grant_o   (pick_grant)
   );

`ifdef SPY_ARB_RR_EN
   logic ptr_q, ptr_d;

   assign ptr_d    = take ? pick_idx : ptr_q;
   assign pick_ptr = ptr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // A constant "last granted = 1" makes every tie resolve to requester 0.
   assign pick_ptr = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of process order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // NOTE: every variable assigned here gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            wait_d = '0;
            if (take) begin
               state_d = m_write[pick_idx] ? WS : RD;
            end
         end
         RD: begin
            if (wait_q == LAST_WAIT) begin
               state_d = DONE;
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end
         WS:      state_d = WT;
         WT:      state_d = WH;
         WH:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state and registered, so the bus
   // strobes and m_ack are glitch-free and line up exactly with their states.
   always_comb begin
      grant_d   = grant_q;
      eadr_d    = eadr_q;
      spy_out_d = spy_out_q;
      rdata_d   = rdata_q;
      if (take) begin
         grant_d = pick_grant;
         eadr_d  = pick_idx ? m_addr[2*ADDR_W-1:ADDR_W] : m_addr[ADDR_W-1:0];
         if (m_write[pick_idx]) begin
            spy_out_d = pick_idx ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
         end
      end
      if ((state_q == RD) && (state_d == DONE)) begin
         rdata_d = spy_in;
      end
      ack_d     = (state_d == DONE) ? grant_q : '0;
      dbread_d  = (state_d == RD);
      dbwrite_d = (state_d == WT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_q   <= '0;
         eadr_q    <= '0;
         spy_out_q <= '0;
         rdata_q   <= '0;
         ack_q     <= '0;
         dbread_q  <= 1'b0;
         dbwrite_q <= 1'b0;
      end else begin
         grant_q   <= grant_d;
         eadr_q    <= eadr_d;
         spy_out_q <= spy_out_d;
         rdata_q   <= rdata_d;
         ack_q     <= ack_d;
         dbread_q  <= dbread_d;
         dbwrite_q <= dbwrite_d;
      end
   end

   assign m_ack   = ack_q;
   assign m_rdata = rdata_q;
   assign eadr    = eadr_q;
   assign dbread  = dbread_q;
   assign dbwrite = dbwrite_q;
   assign spy_out = spy_out_q;

endmodule : spy_bus_arbiter

// File: tb/tb_spy_bus_arbiter.sv
// Scoreboard bench for spy_bus_arbiter: requesters push expected transactions,
// a monitor pops them on m_ack and checks bus activity against a memory model.
module tb_spy_bus_arbiter;

   localparam int RW = 2;

   typedef struct packed {
      logic        wr;
      logic [4:0]  addr;
      logic [15:0] data;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        mv0 = 1'b0, mv1 = 1'b0, mw0 = 1'b0, mw1 = 1'b0;
   logic [4:0]  ma0 = '0, ma1 = '0;
   logic [15:0] md0 = '0, md1 = '0;
   logic [1:0]  m_valid, m_write, m_ack;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic [15:0] m_rdata, spy_out;
   logic [15:0] spy_in = '0;
   logic [4:0]  eadr;
   logic        dbread, dbwrite;

   assign m_valid = {mv1, mv0};
   assign m_write = {mw1, mw0};
   assign m_addr  = {ma1, ma0};
   assign m_wdata = {md1, md0};

   spy_bus_arbiter #(.READ_WAIT(RW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m_valid (m_valid),
      .m_write (m_write),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_ack   (m_ack),
      .m_rdata (m_rdata),
      .eadr    (eadr),
      .dbread  (dbread),
      .dbwrite (dbwrite),
      .spy_out (spy_out),
      .spy_in  (spy_in)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   txn_t        q0[$], q1[$];
   int          ack_log[$];
   int          exp_order[$];
   logic [15:0] slave_mem [32];
   logic [15:0] ref_mem [32];
   logic [15:0] exp_rdata_hold = '0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(int r, logic v, txn_t t);
      if (r == 0) begin mv0 = v; mw0 = t.wr; ma0 = t.addr; md0 = t.data; end
      else        begin mv1 = v; mw1 = t.wr; ma1 = t.addr; md1 = t.data; end
   endtask

   task automatic set_valid(int r, logic v);
      if (r == 0) mv0 = v; else mv1 = v;
   endtask

   task automatic push_exp(int r, txn_t t);
      if (r == 0) q0.push_back(t); else q1.push_back(t);
   endtask

   // Waits for this requester's ack; returns at the negedge where it is seen.
   task automatic wait_ack(int r, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!m_ack[r] && lat < 200);
      check($sformatf("ack_arrived_r%0d", r), 32'(m_ack[r]), 32'd1);
   endtask

   // Spy bus slave: read data is only meaningful in the final dbread cycle.
   initial begin
      int srd = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            srd = 0;
         end else begin
            if (dbwrite) slave_mem[eadr] = spy_out;
            if (dbread) srd++; else srd = 0;
            spy_in = (dbread && srd == RW) ? slave_mem[eadr] : 16'($urandom);
         end
      end
   end

   // Monitor: bus activity between acks, scoreboard pop on each ack.
   initial begin
      int rd_cyc = 0, wr_cyc = 0, idx;
      logic [4:0]  rd_addr = '0, wr_addr = '0;
      logic [15:0] wr_data = '0;
      txn_t t;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            rd_cyc = 0;
            wr_cyc = 0;
            check("ack_in_reset", 32'(m_ack), 32'd0);
         end else begin
            check("rd_wr_exclusive", 32'(dbread & dbwrite), 32'd0);
            if (dbread)  begin rd_cyc++; rd_addr = eadr; end
            if (dbwrite) begin wr_cyc++; wr_addr = eadr; wr_data = spy_out; end
            if (m_ack != 2'b00) begin
               check("ack_onehot", 32'($countones(m_ack)), 32'd1);
               idx = m_ack[1] ? 1 : 0;
               ack_log.push_back(idx);
               if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ack: got m_ack=%b, expected no ack at %0t", m_ack, $time);
               end else begin
                  t = (idx == 0) ? q0.pop_front() : q1.pop_front();
                  if (!t.wr) begin
                     check("rd_strobe_cycles", 32'(rd_cyc), 32'(RW));
                     check("rd_eadr", 32'(rd_addr), 32'(t.addr));
                     check("wr_pulses_on_read", 32'(wr_cyc), 32'd0);
                     check("rdata", 32'(m_rdata), 32'(ref_mem[t.addr]));
                     exp_rdata_hold = ref_mem[t.addr];
                  end else begin
                     check("wr_pulses", 32'(wr_cyc), 32'd1);
                     check("wr_eadr", 32'(wr_addr), 32'(t.addr));
                     check("wr_data", 32'(wr_data), 32'(t.data));
                     check("wr_hold_eadr", 32'(eadr), 32'(t.addr));
                     check("wr_hold_data", 32'(spy_out), 32'(t.data));
                     check("rd_on_write", 32'(rd_cyc), 32'd0);
                     check("rdata_unchanged", 32'(m_rdata), 32'(exp_rdata_hold));
                     ref_mem[t.addr] = t.data;
                  end
               end
               rd_cyc = 0;
               wr_cyc = 0;
            end
         end
      end
   end

   // Random requester: optional idle gap, then one transaction held to its ack.
   task automatic run_req(int r, int n, int max_gap, int addr_max);
      txn_t t;
      int   lat;
      for (int i = 0; i < n; i++) begin
         int gap = $urandom_range(max_gap, 0);
         if (gap > 0) begin
            set_valid(r, 1'b0);
            repeat (gap) @(posedge clk);
            #1;
         end
         t.wr   = 1'($urandom_range(1, 0));
         t.addr = 5'($urandom_range(addr_max, 0));
         t.data = 16'($urandom);
         drive(r, 1'b1, t);
         push_exp(r, t);
         wait_ack(r, lat);
         @(posedge clk);
         #1;
      end
      set_valid(r, 1'b0);
   endtask

   // Single transaction on an idle arbiter; latency counts cycles after the sampling edge.
   task automatic single_txn(int r, logic wr, logic [4:0] a, logic [15:0] d, bit drop_early);
      txn_t t;
      int   lat;
      t.wr = wr; t.addr = a; t.data = d;
      drive(r, 1'b1, t);
      push_exp(r, t);
      @(posedge clk);
      #1;
      if (drop_early) set_valid(r, 1'b0);
      wait_ack(r, lat);
      check($sformatf("latency_%s", wr ? "wr" : "rd"), 32'(lat), wr ? 32'd4 : 32'(RW + 1));
      @(posedge clk);
      #1;
      set_valid(r, 1'b0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      mv0 = 1'b0;
      mv1 = 1'b0;
      q0.delete();
      q1.delete();
      exp_rdata_hold = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic build_order(int n0, int n1);
      int last = 1;
      exp_order.delete();
`ifdef SPY_ARB_RR_EN
      while (n0 > 0 || n1 > 0) begin
         int pick;
         if (n0 > 0 && n1 > 0) pick = (last == 0) ? 1 : 0;
         else                  pick = (n0 > 0) ? 0 : 1;
         exp_order.push_back(pick);
         if (pick == 0) n0--; else n1--;
         last = pick;
      end
`else
      repeat (n0) exp_order.push_back(0);
      repeat (n1) exp_order.push_back(1);
      last = 0;
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      txn_t t;
      for (int i = 0; i < 32; i++) begin
         ref_mem[i]   = 16'($urandom);
         slave_mem[i] = ref_mem[i];
      end
      ref_mem[3]   = 16'h1234;
      slave_mem[3] = 16'h1234;

      #2;
      reset_n = 1'b0;
      #3;
      check("reset_ack", 32'(m_ack), 32'd0);
      check("reset_rdata", 32'(m_rdata), 32'd0);
      check("reset_eadr", 32'(eadr), 32'd0);
      check("reset_dbread", 32'(dbread), 32'd0);
      check("reset_dbwrite", 32'(dbwrite), 32'd0);
      check("reset_spy_out", 32'(spy_out), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed: read of 0x03, write then readback of 0x11, early-drop write.
      single_txn(0, 1'b0, 5'h03, 16'h0000, 1'b0);
      single_txn(1, 1'b1, 5'h11, 16'hBEEF, 1'b0);
      single_txn(0, 1'b0, 5'h11, 16'h0000, 1'b0);
      check("readback_beef", 32'(m_rdata), 32'h0000_BEEF);
      single_txn(0, 1'b1, 5'h04, 16'h5A5A, 1'b1);
      single_txn(1, 1'b0, 5'h04, 16'h0000, 1'b0);

      // Reset in the middle of a read aborts it without an ack.
      t.wr = 1'b0; t.addr = 5'h05; t.data = '0;
      drive(0, 1'b1, t);
      push_exp(0, t);
      @(posedge clk);
      #3;
      check("dbread_before_reset", 32'(dbread), 32'd1);
      reset_n = 1'b0;
      #1;
      check("dbread_async_drop", 32'(dbread), 32'd0);
      check("rdata_async_clear", 32'(m_rdata), 32'd0);
      mv0 = 1'b0;
      q0.delete();
      exp_rdata_hold = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      single_txn(0, 1'b0, 5'h05, 16'h0000, 1'b0);

      // Both requesters back-to-back from a fresh reset.
      do_reset();
      ack_log.delete();
      build_order(4, 4);
      fork
         run_req(0, 4, 0, 7);
         run_req(1, 4, 0, 7);
      join
      check("arb_count", 32'(ack_log.size()), 32'(exp_order.size()));
      for (int i = 0; i < exp_order.size() && i < ack_log.size(); i++) begin
         check($sformatf("arb_order_%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));
      end

      // Random mixed traffic with idle gaps.
      repeat (2) @(posedge clk);
      #1;
      fork
         run_req(0, 30, 3, 7);
         run_req(1, 30, 3, 7);
      join
      repeat (4) @(posedge clk);
      #1;
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_spy_bus_arbiter
